// File: rtl/atriusb_event_writer.sv
// -----------------------------------------------------------------------------
// atriusb_event_writer
//
// Purpose:
//   IRS-clock-domain producer for the USB event FIFO. An event descriptor
//   (header word, payload word count) is taken from the event builder. Once the
//   FIFO has room for the whole block, the header, the word count and the
//   payload words are written back-to-back as one contiguous block. After
//   reset the block runs the FIFO reset request/acknowledge handshake with the
//   USB-side readout before it accepts the first event.
//
// Ports:
//   irs_clk_i       in   1  sole clock, rising edge
//   rst_i           in   1  synchronous, active-high reset
//   ev_start_i      in   1  descriptor strobe, sampled while ev_ready_o=1
//   ev_header_i     in  16  header word
//   ev_nwords_i     in  16  payload word count (clamped to MAX_NWORDS)
//   ev_ready_o      out  1  ready for a new descriptor (IDLE)
//   dat_i           in  16  payload word
//   dat_valid_i     in   1  payload word valid
//   dat_ready_o     out  1  payload word accepted when valid && ready
//   fifo_dat_o      out 16  FIFO write data
//   fifo_wr_o       out  1  FIFO write enable
//   fifo_full_i     in   1  FIFO full
//   fifo_nwords_i   in  16  FIFO free words (saturated, registered at source)
//   fifo_rst_req_o  out  1  FIFO reset request to the readout side
//   fifo_rst_ack_i  in   1  FIFO reset acknowledge (already in irs_clk_i domain)
//   ev_done_o       out  1  one-cycle pulse after the last block word
//   ev_count_o      out 16  completed events, wrapping
//   err_o           out  1  sticky: count clamped or FIFO full during HDR/NW
// -----------------------------------------------------------------------------
module atriusb_event_writer #(
  parameter int unsigned MAX_NWORDS = 65533
) (
  input  logic        irs_clk_i,
  input  logic        rst_i,
  input  logic        ev_start_i,
  input  logic [15:0] ev_header_i,
  input  logic [15:0] ev_nwords_i,
  output logic        ev_ready_o,
  input  logic [15:0] dat_i,
  input  logic        dat_valid_i,
  output logic        dat_ready_o,
  output logic [15:0] fifo_dat_o,
  output logic        fifo_wr_o,
  input  logic        fifo_full_i,
  input  logic [15:0] fifo_nwords_i,
  output logic        fifo_rst_req_o,
  input  logic        fifo_rst_ack_i,
  output logic        ev_done_o,
  output logic [15:0] ev_count_o,
  output logic        err_o
);

  localparam logic [15:0] MAX_NW = 16'(MAX_NWORDS);

  typedef enum logic [2:0] {
    S_RST_REQ,
    S_RST_ACK,
    S_IDLE,
    S_WAIT_SPACE,
    S_HDR,
    S_NW,
    S_DATA,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hdr_q;
  logic [15:0] nw_q;
  logic [15:0] rem_q;
  logic [15:0] ev_count_q;
  logic        space_q;
  logic        err_q;
  logic        space_ok;

  // Free space must cover header + count + payload. 17 bits so that
  // nw_q + 2 cannot wrap for the largest counts.
  assign space_ok = ({1'b0, fifo_nwords_i} >= ({1'b0, nw_q} + 17'd2));

  assign ev_count_o = ev_count_q;
  assign err_o      = err_q;

  // Next-state and outputs.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_d        = state_q;
    ev_ready_o     = 1'b0;
    dat_ready_o    = 1'b0;
    fifo_wr_o      = 1'b0;
    fifo_dat_o     = 16'h0000;
    fifo_rst_req_o = 1'b0;
    ev_done_o      = 1'b0;

    unique case (state_q)
      S_RST_REQ: begin
        fifo_rst_req_o = 1'b1;
        if (fifo_rst_ack_i) state_d = S_RST_ACK;
      end
      S_RST_ACK: begin
        if (!fifo_rst_ack_i) state_d = S_IDLE;
      end
      S_IDLE: begin
        ev_ready_o = 1'b1;
        if (ev_start_i) state_d = S_WAIT_SPACE;
      end
      S_WAIT_SPACE: begin
        // The free-word count lags the FIFO by a cycle, so room must be
        // reported on two consecutive cycles before the block is started.
        if (space_ok && space_q) state_d = S_HDR;
      end
      S_HDR: begin
        if (!fifo_full_i) begin
          fifo_wr_o  = 1'b1;
          fifo_dat_o = hdr_q;
          state_d    = S_NW;
        end
      end
      S_NW: begin
        if (!fifo_full_i) begin
          fifo_wr_o  = 1'b1;
          fifo_dat_o = nw_q;
          state_d    = (nw_q != 16'h0000) ? S_DATA : S_DONE;
        end
      end
      S_DATA: begin
        dat_ready_o = !fifo_full_i;
        if (dat_valid_i && !fifo_full_i) begin
          fifo_wr_o  = 1'b1;
          fifo_dat_o = dat_i;
          if (rem_q == 16'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        ev_done_o = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_RST_REQ;
    endcase

    // A reset abandons the event immediately: no write or payload accept in
    // the cycle rst_i is sampled, even though state_q still shows the event.
    if (rst_i) begin
      fifo_wr_o   = 1'b0;
      fifo_dat_o  = 16'h0000;
      dat_ready_o = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge irs_clk_i) begin
    if (rst_i) begin
      // NOTE: the descriptor registers are reset as well, so that nothing
      // downstream (including space_ok) ever sees X after power-up.
      state_q    <= S_RST_REQ;
      hdr_q      <= 16'h0000;
      nw_q       <= 16'h0000;
      rem_q      <= 16'h0000;
      ev_count_q <= 16'h0000;
      space_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register here samples
      // the pre-edge value of every other register.
      state_q <= state_d;
      space_q <= (state_q == S_WAIT_SPACE) && space_ok && (state_d == S_WAIT_SPACE);

      unique case (state_q)
        S_IDLE: begin
          if (ev_start_i) begin
            hdr_q <= ev_header_i;
            if (ev_nwords_i > MAX_NW) begin
              nw_q  <= MAX_NW;
              err_q <= 1'b1;
            end else begin
              nw_q <= ev_nwords_i;
            end
          end
        end
        S_HDR: begin
          if (fifo_full_i) err_q <= 1'b1;
        end
        S_NW: begin
          if (fifo_full_i) err_q <= 1'b1;
          else             rem_q <= nw_q;
        end
        S_DATA: begin
          if (fifo_wr_o) rem_q <= rem_q - 16'd1;
        end
        S_DONE: begin
          ev_count_q <= ev_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
